vx_csr_commit_counter: RTL and testbench

CSR-side receiver of the commit-to-CSR channel. Accumulates the per-cycle `commit_size` reported by the commit stage into a 64-bit retired-instruction counter (`minstret`) and runs a free-running 64-bit cycle counter (`mcycle`). It exposes both counters to the CSR unit through a registered read port and a write port. It sits inside the CSR data path, directly behind the commit stage.

---
 rtl/vx_csr_commit_counter_if.sv | 47 ++++
 rtl/vx_csr_commit_counter.sv | 119 +++++++++++
 tb/tb_vx_csr_commit_counter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vx_csr_commit_counter_if.sv
// Commit-to-CSR channel plus CSR read/write port of the commit counter block.
// master: commit stage / CSR unit side. slave: the counter block.
interface vx_csr_commit_counter_if #(
    parameter int unsigned CSIZE_W = 5
);
    // Commit report (no backpressure)
    logic               cmt_valid;
    logic [CSIZE_W-1:0] cmt_commit_size;

    // CSR read port, response registered one cycle after the request
    logic               read_enable;
    logic [11:0]        read_addr;
    logic               read_valid;
    logic [31:0]        read_data;
    logic               read_err;

    // CSR write port
    logic               write_enable;
    logic [11:0]        write_addr;
    logic [31:0]        write_data;

    modport master (
        output cmt_valid,
        output cmt_commit_size,
        output read_enable,
        output read_addr,
        input  read_valid,
        input  read_data,
        input  read_err,
        output write_enable,
        output write_addr,
        output write_data
    );

    modport slave (
        input  cmt_valid,
        input  cmt_commit_size,
        input  read_enable,
        input  read_addr,
        output read_valid,
        output read_data,
        output read_err,
        input  write_enable,
        input  write_addr,
        input  write_data
    );
endinterface

// File: rtl/vx_csr_commit_counter.sv
// CSR-side receiver of the commit channel: 64-bit minstret accumulated from
// per-cycle commit sizes, free-running 64-bit mcycle, registered CSR read port
// and a write port that overrides the same-cycle increment.
module vx_csr_commit_counter #(
    parameter int unsigned NUM_THREADS  = 4,
    parameter int unsigned EXT_F_ENABLE = 1,
    parameter int unsigned CSIZE_W      = (EXT_F_ENABLE != 0) ?
                                          $clog2(6 * NUM_THREADS + 1) :
                                          $clog2(5 * NUM_THREADS + 1)
) (
    input logic                    clk,
    input logic                    reset,
    vx_csr_commit_counter_if.slave bus
);

    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMcycleH   = 12'hB80;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMinstretH = 12'hB82;
    localparam logic [11:0] AddrCycle     = 12'hC00;
    localparam logic [11:0] AddrCycleH    = 12'hC80;
    localparam logic [11:0] AddrInstret   = 12'hC02;
    localparam logic [11:0] AddrInstretH  = 12'hC82;

    // Commit input stage
    logic               pend_valid_q, pend_valid_d;
    logic [CSIZE_W-1:0] pend_size_q, pend_size_d;

    // Counters
    logic [63:0]        mcycle_q, mcycle_d;
    logic [63:0]        minstret_q, minstret_d;

    // Read response
    logic               read_valid_q, read_valid_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               read_err_q, read_err_d;

    // Read decode of the current (pre-update) counter values
    logic [31:0]        rd_value;
    logic               rd_hit;

    // Capture the commit report; a cycle without cmt_valid clears the pending flag
    always_comb begin
        pend_valid_d = bus.cmt_valid;
        pend_size_d  = pend_size_q;
        if (bus.cmt_valid) begin
            pend_size_d = bus.cmt_commit_size;
        end
    end

    // Counter next state: increment first, then a write to a half overrides the
    // whole counter so the increment (and its carry) is discarded that cycle
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q;
        if (pend_valid_q) begin
            minstret_d = minstret_q + 64'(pend_size_q);
        end
        if (bus.write_enable) begin
            case (bus.write_addr)
                AddrMcycle:    mcycle_d   = {mcycle_q[63:32], bus.write_data};
                AddrMcycleH:   mcycle_d   = {bus.write_data, mcycle_q[31:0]};
                AddrMinstret:  minstret_d = {minstret_q[63:32], bus.write_data};
                AddrMinstretH: minstret_d = {bus.write_data, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // Decode the read address against the owned CSRs and their user aliases
    always_comb begin
        rd_hit   = 1'b1;
        rd_value = 32'd0;
        case (bus.read_addr)
            AddrMcycle,    AddrCycle:    rd_value = mcycle_q[31:0];
            AddrMcycleH,   AddrCycleH:   rd_value = mcycle_q[63:32];
            AddrMinstret,  AddrInstret:  rd_value = minstret_q[31:0];
            AddrMinstretH, AddrInstretH: rd_value = minstret_q[63:32];
            default: rd_hit = 1'b0;
        endcase
    end

    // Read response next state; data and error hold when no read is accepted
    always_comb begin
        read_valid_d = bus.read_enable;
        read_data_d  = read_data_q;
        read_err_d   = read_err_q;
        if (bus.read_enable) begin
            read_data_d = rd_value;
            read_err_d  = ~rd_hit;
        end
    end

    // State registers with synchronous reset; reset drops any pending commit
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_size_q  <= '0;
            mcycle_q     <= 64'd0;
            minstret_q   <= 64'd0;
            read_valid_q <= 1'b0;
            read_data_q  <= 32'd0;
            read_err_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_size_q  <= pend_size_d;
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
            read_valid_q <= read_valid_d;
            read_data_q  <= read_data_d;
            read_err_q   <= read_err_d;
        end
    end

    assign bus.read_valid = read_valid_q;
    assign bus.read_data  = read_data_q;
    assign bus.read_err   = read_err_q;

endmodule

// File: tb/tb_vx_csr_commit_counter.sv
// Directed bench for vx_csr_commit_counter: hand-computed expectations for
// reset, commit accumulation, 64-bit wrap, write priority, mcycle and reads.
module tb_vx_csr_commit_counter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cyc;

    vx_csr_commit_counter_if #(.CSIZE_W(5)) bus ();

    vx_csr_commit_counter #(
        .NUM_THREADS (4),
        .EXT_F_ENABLE(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_read(input string tag, input logic [11:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        bus.read_enable = 1'b1;
        bus.read_addr   = addr;
        tick();
        bus.read_enable = 1'b0;
        check_eq({tag, ".valid"}, 32'(bus.read_valid), 32'd1);
        check_eq({tag, ".data"}, bus.read_data, exp_data);
        check_eq({tag, ".err"}, 32'(bus.read_err), 32'(exp_err));
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data);
        bus.write_enable = 1'b1;
        bus.write_addr   = addr;
        bus.write_data   = data;
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic commit(input logic [4:0] size);
        bus.cmt_valid       = 1'b1;
        bus.cmt_commit_size = size;
        tick();
        bus.cmt_valid       = 1'b0;
    endtask

    // Hold reset for a few cycles, release it; the release cycle is cycle 0
    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.cmt_valid       = 1'b0;
        bus.cmt_commit_size = '0;
        bus.read_enable     = 1'b0;
        bus.read_addr       = '0;
        bus.write_enable    = 1'b0;
        bus.write_addr      = '0;
        bus.write_data      = '0;

        // Reset values of the read port
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst.valid", 32'(bus.read_valid), 32'd0);
        check_eq("rst.data", bus.read_data, 32'd0);
        check_eq("rst.err", 32'(bus.read_err), 32'd0);
        reset = 1'b0;
        cyc   = 0;

        // minstret starts at zero (reads issued in cycles 0 and 1)
        do_read("rst.minstret_lo", 12'hB02, 32'd0, 1'b0);
        do_read("rst.minstret_hi", 12'hB82, 32'd0, 1'b0);
        // Idle cycle: no response valid, data held
        tick();
        check_eq("idle.valid", 32'(bus.read_valid), 32'd0);
        check_eq("idle.data_hold", bus.read_data, 32'd0);

        // mcycle: read in cycle k returns k
        while (cyc < 10) tick();
        do_read("mcycle.c10", 12'hB00, 32'd10, 1'b0);
        do_read("mcycle.hi", 12'hB80, 32'd0, 1'b0);
        do_read("cycle.alias.c12", 12'hC00, 32'd12, 1'b0);
        while (cyc < 20) tick();
        do_write(12'hB00, 32'd100);
        while (cyc < 23) tick();
        do_read("mcycle.write", 12'hB00, 32'd102, 1'b0);

        // Back-to-back commits 4,0,24,1 then two idle cycles
        commit(5'd4);
        commit(5'd0);
        commit(5'd24);
        commit(5'd1);
        tick();
        tick();
        do_read("commit.sum", 12'hC02, 32'd29, 1'b0);

        // 64-bit wrap: all-ones + 3 = 2
        do_write(12'hB02, 32'hFFFF_FFFF);
        do_write(12'hB82, 32'hFFFF_FFFF);
        commit(5'd3);
        tick();
        do_read("wrap.lo", 12'hB02, 32'd2, 1'b0);
        do_read("wrap.hi", 12'hB82, 32'd0, 1'b0);

        // Write in the same cycle the size-5 commit is pending: increment dropped
        bus.cmt_valid       = 1'b1;
        bus.cmt_commit_size = 5'd5;
        tick();
        bus.cmt_valid = 1'b0;
        do_write(12'hB02, 32'hFFFF_FFFE);
        tick();
        do_read("prio.lo", 12'hB02, 32'hFFFF_FFFE, 1'b0);
        do_read("prio.hi", 12'hB82, 32'd0, 1'b0);

        // Same-cycle read and write: old value returned, write lands
        bus.write_enable = 1'b1;
        bus.write_addr   = 12'hB02;
        bus.write_data   = 32'h0000_1234;
        do_read("rw.old", 12'hB02, 32'hFFFF_FFFE, 1'b0);
        bus.write_enable = 1'b0;
        do_read("rw.new", 12'hB02, 32'h0000_1234, 1'b0);

        // Write to alias is ignored
        do_write(12'hC02, 32'd77);
        do_read("alias.wr", 12'hB02, 32'h0000_1234, 1'b0);

        // Unowned address
        do_read("unowned", 12'h300, 32'd0, 1'b1);

        // Reset while a size-7 commit is pending
        commit(5'd7);
        apply_reset();
        do_read("rst.pend", 12'hB02, 32'd0, 1'b0);
        do_read("rst.pend_hi", 12'hB82, 32'd0, 1'b0);
        do_read("rst.mcycle", 12'hB00, 32'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
